branch_resolver: RTL

//  Execute-side counterpart of the dynamic branch predictor. It queues each fetch-time prediction
//  (PC, taken bit, target) in order and checks it against the real outcome when the branch resolves in EX.
//  On a mispredict it pulses flush, gives the corrected PC to fetch and squashes younger queued predictions.
//  It returns a one-cycle training update (PC, actual outcome) to the predictor.

---
 rtl/branch_resolver.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: execute-side checker for the dynamic branch predictor.
// Fetch-time predictions are queued in order and compared with EX resolutions.
// A mispredict flushes the front end, redirects fetch and squashes the queue.
// Optional feature: define BRANCH_RESOLVER_STATS_EN to add the stat_branches and
// stat_mispredicts counters (saturating, cleared by rst).
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  output logic            pred_ready,
  input  logic [XLEN-1:0] pred_pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_valid,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic            upd_mispredict,
  output logic            busy
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [XLEN-1:0] mem_pc_q [DEPTH];
  logic [XLEN-1:0] mem_target_q [DEPTH];
  logic            mem_taken_q [DEPTH];

  logic            pred_ready_q, pred_ready_d, res_ready_q, res_ready_d;
  logic            busy_q, busy_d, flush_q, flush_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d, upd_pc_q, upd_pc_d;
  logic            upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic            upd_mispredict_q, upd_mispredict_d;

  logic            push_s, pop_s, mis_s, wr_en_s;
  logic [XLEN-1:0] head_pc_s, head_target_s;
  logic            head_taken_s;

  assign head_pc_s     = mem_pc_q[head_q];
  assign head_target_s = mem_target_q[head_q];
  assign head_taken_s  = mem_taken_q[head_q];
  assign push_s        = pred_valid && pred_ready_q;
  assign pop_s         = res_valid && res_ready_q;
  assign mis_s         = (head_taken_s != res_taken) || (res_taken && (head_target_s != res_target));

  // Next-state logic: queue bookkeeping, flush sequencing and registered output values.
  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    wr_en_s          = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    upd_valid_d      = 1'b0;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    upd_mispredict_d = upd_mispredict_q;
    case (state_q)
      ST_RUN: begin
        if (pop_s) begin
          upd_valid_d      = 1'b1;
          upd_pc_d         = head_pc_s;
          upd_taken_d      = res_taken;
          upd_mispredict_d = mis_s;
          if (mis_s) begin
            // Squash everything younger; a same-cycle push is dropped below.
            head_d           = '0;
            tail_d           = '0;
            count_d          = '0;
            state_d          = ST_FLUSH;
            fcnt_d           = FCW'(FLUSH_CYCLES - 1);
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = res_taken ? res_target
                                         : head_pc_s + {{(XLEN-3){1'b0}}, 3'b100};
          end else begin
            head_d  = head_q + AW'(1);
            count_d = count_q - CNTW'(1);
          end
        end else begin
          head_d = head_q;
        end
        if (push_s && !(pop_s && mis_s)) begin
          wr_en_s = 1'b1;
          tail_d  = tail_q + AW'(1);
          count_d = count_d + CNTW'(1);
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // Handshake/status flops track the state the queue will be in next cycle.
    pred_ready_d = (state_d == ST_RUN) && (count_d != CNTW'(DEPTH));
    res_ready_d  = (state_d == ST_RUN) && (count_d != '0);
    busy_d       = (count_d != '0) || (state_d == ST_FLUSH);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_RUN;
      fcnt_q           <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      pred_ready_q     <= 1'b0;
      res_ready_q      <= 1'b0;
      busy_q           <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_mispredict_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      pred_ready_q     <= pred_ready_d;
      res_ready_q      <= res_ready_d;
      busy_q           <= busy_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      upd_mispredict_q <= upd_mispredict_d;
    end
  end

  // Prediction record storage, written at the tail on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]     <= '0;
        mem_target_q[i] <= '0;
        mem_taken_q[i]  <= 1'b0;
      end
    end else if (wr_en_s) begin
      mem_pc_q[tail_q]     <= pred_pc;
      mem_target_q[tail_q] <= pred_target;
      mem_taken_q[tail_q]  <= pred_taken;
    end
  end

  assign pred_ready     = pred_ready_q;
  assign res_ready      = res_ready_q;
  assign busy           = busy_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_mispredict = upd_mispredict_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d, stat_mispredicts_q, stat_mispredicts_d;

  // Saturating event counters for consumed resolutions and mispredicts.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (pop_s && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end else begin
      stat_branches_d = stat_branches_q;
    end
    if (pop_s && mis_s && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end else begin
      stat_mispredicts_d = stat_mispredicts_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
